// File: rtl/shadow_stack_pkg.sv
// Shared constants and types for the return-address shadow stack.
package shadow_stack_pkg;

  // Overflow policy selectors for OVF_MODE.
  localparam int unsigned OVF_BLOCK = 0;
  localparam int unsigned OVF_WRAP  = 1;

  // At most one error class can occur per cycle, so one encoded register holds them.
  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UNF  = 2'd2,
    ERR_MIS  = 2'd3
  } err_t;

  // Ceiling log2, used for pointer width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shadow_stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset
// so it can map onto distributed RAM.
module shadow_stack_mem #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read of the addressed entry.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/shadow_stack_ctrl.sv
// Return-address shadow stack controller: pointer/count management, pop-and-compare,
// registered error pulses and a sticky violation flag.
module shadow_stack_ctrl
  import shadow_stack_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned OVF_MODE = 0,
  parameter int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_valid,
  input  logic [WIDTH-1:0] pop_data,
  input  logic             viol_clr,
  output logic [WIDTH-1:0] top_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             chk_valid,
  output logic             chk_match,
  output logic             overflow_err,
  output logic             underflow_err,
  output logic             mismatch_err,
  output logic             violation
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam bit          WrapMode = (OVF_MODE == OVF_WRAP);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] top_idx;
  logic [ADDR_W-1:0] mem_waddr;
  logic              mem_we;
  logic [WIDTH-1:0]  rd_data;
  logic              is_empty, is_full, hit;
  err_t              err_d, err_q;
  logic              chk_valid_d, chk_valid_q;
  logic              chk_match_d, chk_match_q;
  logic              violation_d, violation_q;

  assign top_idx  = wr_ptr_q - ADDR_W'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign hit      = (rd_data == pop_data);

  shadow_stack_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (push_data),
    .raddr (top_idx),
    .rdata (rd_data)
  );

  // Next-state, memory write and error decode for push/pop/flush.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;
    err_d       = ERR_NONE;
    chk_valid_d = 1'b0;
    chk_match_d = 1'b0;

    if (flush) begin
      // Flush swallows any same-cycle push/pop without reporting errors.
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (push_valid && pop_valid) begin
      chk_valid_d = 1'b1;
      if (is_empty) begin
        err_d    = ERR_UNF;
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        count_d  = CNT_W'(1);
      end else begin
        // Compare against current top, then overwrite that same slot.
        chk_match_d = hit;
        mem_we      = 1'b1;
        mem_waddr   = top_idx;
        if (!hit) begin
          err_d = ERR_MIS;
        end
      end
    end else if (push_valid) begin
      if (!is_full) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        count_d  = count_q + CNT_W'(1);
      end else if (WrapMode) begin
        // Overwrites the oldest entry; count saturates at DEPTH.
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end else begin
        err_d = ERR_OVF;
      end
    end else if (pop_valid) begin
      chk_valid_d = 1'b1;
      if (is_empty) begin
        err_d = ERR_UNF;
      end else begin
        chk_match_d = hit;
        wr_ptr_d    = wr_ptr_q - ADDR_W'(1);
        count_d     = count_q - CNT_W'(1);
        if (!hit) begin
          err_d = ERR_MIS;
        end
      end
    end

    // A new error takes precedence over a same-cycle clear.
    violation_d = (err_d != ERR_NONE) || (violation_q && !viol_clr);
  end

  // State and registered result/error outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      err_q       <= ERR_NONE;
      chk_valid_q <= 1'b0;
      chk_match_q <= 1'b0;
      violation_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      chk_valid_q <= chk_valid_d;
      chk_match_q <= chk_match_d;
      violation_q <= violation_d;
    end
  end

  // Output decode.
  always_comb begin
    top_data      = is_empty ? '0 : rd_data;
    count         = count_q;
    empty         = is_empty;
    full          = is_full;
    chk_valid     = chk_valid_q;
    chk_match     = chk_match_q;
    overflow_err  = (err_q == ERR_OVF);
    underflow_err = (err_q == ERR_UNF);
    mismatch_err  = (err_q == ERR_MIS);
    violation     = violation_q;
  end

endmodule

// File: tb/tb_shadow_stack_ctrl.sv
// Directed bench: three stacks (DEPTH=4 BLOCK, DEPTH=4 WRAP, default 128) share one
// stimulus stream; each is checked against hand-computed values.
module tb_shadow_stack_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic [31:0] push_data = '0;
  logic        pop_valid = 1'b0;
  logic [31:0] pop_data = '0;
  logic        viol_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // DEPTH=4, BLOCK
  logic [31:0] b_top;
  logic [2:0]  b_count;
  logic b_empty, b_full, b_cv, b_cm, b_ovf, b_unf, b_mis, b_viol;
  // DEPTH=4, WRAP
  logic [31:0] w_top;
  logic [2:0]  w_count;
  logic w_empty, w_full, w_cv, w_cm, w_ovf, w_unf, w_mis, w_viol;
  // DEPTH=128, BLOCK (defaults)
  logic [31:0] d_top;
  logic [7:0]  d_count;
  logic d_empty, d_full, d_cv, d_cm, d_ovf, d_unf, d_mis, d_viol;

  shadow_stack_ctrl #(.WIDTH(32), .DEPTH(4), .OVF_MODE(0)) u_blk (
    .clk(clk), .reset_n(reset_n), .flush(flush), .push_valid(push_valid),
    .push_data(push_data), .pop_valid(pop_valid), .pop_data(pop_data), .viol_clr(viol_clr),
    .top_data(b_top), .count(b_count), .empty(b_empty), .full(b_full), .chk_valid(b_cv),
    .chk_match(b_cm), .overflow_err(b_ovf), .underflow_err(b_unf), .mismatch_err(b_mis),
    .violation(b_viol)
  );

  shadow_stack_ctrl #(.WIDTH(32), .DEPTH(4), .OVF_MODE(1)) u_wrp (
    .clk(clk), .reset_n(reset_n), .flush(flush), .push_valid(push_valid),
    .push_data(push_data), .pop_valid(pop_valid), .pop_data(pop_data), .viol_clr(viol_clr),
    .top_data(w_top), .count(w_count), .empty(w_empty), .full(w_full), .chk_valid(w_cv),
    .chk_match(w_cm), .overflow_err(w_ovf), .underflow_err(w_unf), .mismatch_err(w_mis),
    .violation(w_viol)
  );

  shadow_stack_ctrl u_dfl (
    .clk(clk), .reset_n(reset_n), .flush(flush), .push_valid(push_valid),
    .push_data(push_data), .pop_valid(pop_valid), .pop_data(pop_data), .viol_clr(viol_clr),
    .top_data(d_top), .count(d_count), .empty(d_empty), .full(d_full), .chk_valid(d_cv),
    .chk_match(d_cm), .overflow_err(d_ovf), .underflow_err(d_unf), .mismatch_err(d_mis),
    .violation(d_viol)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] d);
    push_valid = 1'b1;
    push_data  = d;
    cyc();
    push_valid = 1'b0;
  endtask

  task automatic do_pop(input logic [31:0] d);
    pop_valid = 1'b1;
    pop_data  = d;
    cyc();
    pop_valid = 1'b0;
  endtask

  task automatic do_flush_clr();
    flush    = 1'b1;
    viol_clr = 1'b1;
    cyc();
    flush    = 1'b0;
    viol_clr = 1'b0;
  endtask

  initial begin
    #12;
    // Reset state
    check("rst_count", 32'(d_count), 32'd0);
    check("rst_empty", 32'(d_empty), 32'd1);
    check("rst_full", 32'(b_full), 32'd0);
    check("rst_top", d_top, 32'h0);
    check("rst_cv", 32'(d_cv), 32'd0);
    check("rst_viol", 32'(d_viol), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    // Basic push/pop-compare
    do_push(32'h100);
    do_push(32'h200);
    do_push(32'h300);
    check("s1_count", 32'(d_count), 32'd3);
    check("s1_top", d_top, 32'h300);
    do_pop(32'h300);
    check("s1_cv", 32'(d_cv), 32'd1);
    check("s1_cm", 32'(d_cm), 32'd1);
    check("s1_count2", 32'(d_count), 32'd2);
    check("s1_viol", 32'(d_viol), 32'd0);
    check("s1_top2", d_top, 32'h200);
    do_flush_clr();

    // Fill the DEPTH=4 stacks, then overflow
    do_push(32'h10);
    do_push(32'h20);
    do_push(32'h30);
    check("ovf_notfull", 32'(b_full), 32'd0);
    do_push(32'h40);
    check("ovf_full_b", 32'(b_full), 32'd1);
    check("ovf_full_w", 32'(w_full), 32'd1);
    do_push(32'h50);
    check("ovf_err_b", 32'(b_ovf), 32'd1);
    check("ovf_viol_b", 32'(b_viol), 32'd1);
    check("ovf_top_b", b_top, 32'h40);
    check("ovf_count_b", 32'(b_count), 32'd4);
    check("wrap_noerr", 32'(w_ovf), 32'd0);
    check("wrap_noviol", 32'(w_viol), 32'd0);
    check("wrap_top", w_top, 32'h50);
    check("wrap_count", 32'(w_count), 32'd4);
    check("dfl_count5", 32'(d_count), 32'd5);
    cyc();
    check("ovf_pulse_end", 32'(b_ovf), 32'd0);
    check("ovf_sticky", 32'(b_viol), 32'd1);
    viol_clr = 1'b1;
    cyc();
    viol_clr = 1'b0;
    check("ovf_vclr", 32'(b_viol), 32'd0);
    do_push(32'h60);
    check("wrap_count6", 32'(w_count), 32'd4);
    check("wrap_top6", w_top, 32'h60);
    check("ovf_err_b2", 32'(b_ovf), 32'd1);

    // WRAP pops return newest four
    do_pop(32'h60);
    check("wpop60_cm", 32'(w_cm), 32'd1);
    check("bpop_mis", 32'(b_mis), 32'd1);
    do_pop(32'h50);
    check("wpop50_cm", 32'(w_cm), 32'd1);
    do_pop(32'h40);
    check("wpop40_cm", 32'(w_cm), 32'd1);
    do_pop(32'h30);
    check("wpop30_cm", 32'(w_cm), 32'd1);
    check("wpop_count", 32'(w_count), 32'd0);
    check("wpop_nomis", 32'(w_mis), 32'd0);
    check("dpop_count", 32'(d_count), 32'd2);
    do_pop(32'h0);
    check("wunf_cv", 32'(w_cv), 32'd1);
    check("wunf_cm", 32'(w_cm), 32'd0);
    check("wunf_err", 32'(w_unf), 32'd1);
    check("wunf_viol", 32'(w_viol), 32'd1);
    check("bunf_err", 32'(b_unf), 32'd1);
    check("dmis_err", 32'(d_mis), 32'd1);
    do_flush_clr();
    check("fl_viol_clr", 32'(w_viol), 32'd0);
    check("fl_empty", 32'(w_empty), 32'd1);

    // Mismatch and sticky clear
    do_push(32'hA0);
    do_pop(32'hA4);
    check("mis_err", 32'(d_mis), 32'd1);
    check("mis_cm", 32'(d_cm), 32'd0);
    check("mis_viol", 32'(d_viol), 32'd1);
    check("mis_count", 32'(d_count), 32'd0);
    cyc();
    check("mis_pulse_end", 32'(d_mis), 32'd0);
    check("mis_sticky", 32'(d_viol), 32'd1);
    viol_clr = 1'b1;
    cyc();
    viol_clr = 1'b0;
    check("mis_vclr", 32'(d_viol), 32'd0);

    // Simultaneous push+pop replaces top
    do_push(32'h11);
    do_push(32'h22);
    push_valid = 1'b1;
    push_data  = 32'h33;
    pop_valid  = 1'b1;
    pop_data   = 32'h22;
    cyc();
    push_valid = 1'b0;
    pop_valid  = 1'b0;
    check("pp_cm", 32'(d_cm), 32'd1);
    check("pp_count", 32'(d_count), 32'd2);
    check("pp_top", d_top, 32'h33);
    check("pp_nomis", 32'(d_mis), 32'd0);
    do_pop(32'h33);
    check("pp_pop33", 32'(d_cm), 32'd1);
    do_pop(32'h11);
    check("pp_pop11", 32'(d_cm), 32'd1);
    check("pp_empty", 32'(d_empty), 32'd1);

    // Simultaneous push+pop on empty: underflow then push
    push_valid = 1'b1;
    push_data  = 32'h77;
    pop_valid  = 1'b1;
    pop_data   = 32'h0;
    cyc();
    push_valid = 1'b0;
    pop_valid  = 1'b0;
    check("ppe_unf", 32'(d_unf), 32'd1);
    check("ppe_count", 32'(d_count), 32'd1);
    check("ppe_top", d_top, 32'h77);
    // Clear and a new error together: set wins
    viol_clr = 1'b1;
    do_pop(32'h78);
    viol_clr = 1'b0;
    check("setwin_viol", 32'(d_viol), 32'd1);
    check("setwin_mis", 32'(d_mis), 32'd1);
    do_flush_clr();

    // Flush beats push/pop, no error pulses
    do_push(32'h1);
    do_push(32'h2);
    do_push(32'h3);
    flush      = 1'b1;
    push_valid = 1'b1;
    push_data  = 32'h4;
    cyc();
    check("flp_count", 32'(d_count), 32'd0);
    check("flp_empty", 32'(d_empty), 32'd1);
    check("flp_ovf", 32'(d_ovf), 32'd0);
    push_valid = 1'b0;
    pop_valid  = 1'b1;
    cyc();
    flush     = 1'b0;
    pop_valid = 1'b0;
    check("flpop_unf", 32'(d_unf), 32'd0);
    check("flpop_cv", 32'(d_cv), 32'd0);
    check("flpop_viol", 32'(d_viol), 32'd0);

    // Async reset in the middle of a pop
    do_push(32'h5);
    viol_clr   = 1'b0;
    pop_valid  = 1'b1;
    pop_data   = 32'h6;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_count", 32'(d_count), 32'd0);
    check("arst_top", d_top, 32'h0);
    check("arst_empty", 32'(d_empty), 32'd1);
    cyc();
    check("arst_cv", 32'(d_cv), 32'd0);
    check("arst_mis", 32'(d_mis), 32'd0);
    check("arst_viol", 32'(d_viol), 32'd0);
    pop_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    check("post_rst_empty", 32'(b_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shadow_stack_ctrl.md
Name: shadow_stack_ctrl

Overview:
- Parametrised hardware return-address shadow stack for the mor1kx cappuccino pipeline; successor to the fixed 128x32 single-mode stack.
- Calls push the link address. Returns pop the top entry and compare it with the address the CPU is about to jump to.
- Adds configurable width/depth, an overflow policy (block or wrap), simultaneous push+pop, pop-and-compare, per-event error pulses and a sticky violation flag for the monitor/observer.

Parameters:
- WIDTH, 32, entry/address width in bits.
- DEPTH, 128, number of entries; must be a power of two, >= 4.
- OVF_MODE, 0, 0 = BLOCK (push when full is dropped and flagged), 1 = WRAP (push when full overwrites oldest entry, no flag).
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of the stack; highest priority.
- push_valid  in  1  call retired; push push_data this cycle.
- push_data  in  WIDTH  return address to save.
- pop_valid  in  1  return retired; pop and compare.
- pop_data  in  WIDTH  actual return target to check.
- viol_clr  in  1  clears sticky violation.
- top_data  out  WIDTH  current top entry; 0 when empty.
- count  out  CNT_W  entries held, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- chk_valid  out  1  compare result valid (one cycle after pop_valid).
- chk_match  out  1  popped entry equalled pop_data.
- overflow_err  out  1  one-cycle pulse: push dropped (BLOCK mode only).
- underflow_err  out  1  one-cycle pulse: pop while empty.
- mismatch_err  out  1  one-cycle pulse: pop on non-empty stack with compare fail.
- violation  out  1  sticky OR of all error pulses.

Behaviour:
- Reset (reset_n low, async): wr_ptr = 0, count = 0, all registered outputs 0, empty = 1, full = 0. Storage array is not reset, so it can map to FPGA RAM.
- Pointers:
  - wr_ptr (ADDR_W = $clog2(DEPTH)) indexes the next free slot.
  - top index = wr_ptr-1 mod DEPTH.
  - All pointer arithmetic is modulo DEPTH (natural ADDR_W wrap).
- top_data is a combinational read of the top index, forced to 0 when count == 0.
- Push only (push_valid & !pop_valid):
  - not full: mem[wr_ptr] <= push_data, wr_ptr+1, count+1.
  - full, BLOCK: no write, state unchanged, overflow_err = 1 next cycle, violation set.
  - full, WRAP: mem[wr_ptr] <= push_data, wr_ptr+1, count stays DEPTH. The oldest entry is lost silently.
- Pop only (pop_valid & !push_valid):
  - non-empty: wr_ptr-1, count-1. Next cycle chk_valid = 1 and chk_match = (top_data == pop_data), sampled at the pop cycle. On a miss, mismatch_err = 1.
  - empty: state unchanged. Next cycle chk_valid = 1, chk_match = 0, underflow_err = 1.
- Push and pop in the same cycle:
  - Pop compares against the current top, then push_data replaces that slot.
  - wr_ptr and count are unchanged, so no overflow is possible even when full.
  - If empty: underflow_err is flagged, then push proceeds normally (count becomes 1).
- Flush: wr_ptr = 0 and count = 0 next cycle. Any push/pop in the same cycle is ignored with no error pulses. violation is NOT cleared by flush.
- violation:
  - set the cycle any error pulse is asserted; held until viol_clr.
  - viol_clr and a new error in the same cycle: set wins.
- Latency: state update in 1 cycle; compare result and error pulses are registered, 1 cycle after the request.
- Reset mid-operation: all in-flight compare results are discarded and outputs go to reset values immediately.

Decomposition:
- Package shadow_stack_pkg:
  - OVF_BLOCK = 0 and OVF_WRAP = 1 constants.
  - err_t enum: ERR_NONE, ERR_OVF, ERR_UNF, ERR_MIS.
  - function clog2 for pointer width.
- Sub-module shadow_stack_mem: DEPTH x WIDTH array with one synchronous write port and one asynchronous read port, no reset. The controller (pointers, count, compare, error logic) stays in shadow_stack_ctrl.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 -> count = 3, top_data = 0x300. Pop with pop_data = 0x300 -> chk_valid = 1, chk_match = 1, count = 2, violation = 0.
- DEPTH = 4, BLOCK: push 5 values 0x10..0x50 -> full = 1 after the 4th. 5th push -> overflow_err pulse, violation = 1, top_data stays 0x40.
- DEPTH = 4, WRAP: push 0x10..0x60 -> count = 4, no errors. Pops return 0x60, 0x50, 0x40, 0x30 with matches. A 5th pop -> underflow_err, chk_match = 0.
- Push 0xA0, then pop with pop_data = 0xA4 -> mismatch_err pulse, violation = 1. viol_clr -> violation = 0 next cycle.
- Stack holding 0x11, 0x22; simultaneous push 0x33 and pop with pop_data = 0x22 -> chk_match = 1, count stays 2, top_data = 0x33.
- Push 3 entries, flush and push in the same cycle -> count = 0, empty = 1, no error pulse. Assert reset_n low mid-pop -> chk_valid stays 0 and all outputs are 0 asynchronously.
